// File: rtl/mage_dma_ch_driver.sv
// Initiator end of one Mage HW-FIFO DMA channel.
// Moves len words per transfer between a memory-side valid/ready stream and
// the Mage push/pop FIFO interface. A DEPTH-entry circular buffer decouples
// the two sides and provides the single register stage in the data path.
module mage_dma_ch_driver #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  output logic              mem_valid_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ready_i,
  output logic              fifo_push_o,
  output logic [DATA_W-1:0] fifo_data_o,
  input  logic              fifo_full_i,
  output logic              fifo_pop_o,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          dir_q, dir_d;
  logic [CNT_W-1:0]              len_q, len_d;
  logic [CNT_W-1:0]              in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]              out_cnt_q, out_cnt_d;
  logic [PW-1:0]                 wptr_q, wptr_d;
  logic [PW-1:0]                 rptr_q, rptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  buf_q;

  logic              run, in_left, buf_empty, buf_full;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] wr_data, head;

  // Buffer status and handshakes; ready/pop qualifiers use registered state
  // only, so nothing combinational runs from the far side's flow control
  // into the near side's ready.
  assign run       = (state_q == RUN);
  assign in_left   = (in_cnt_q < len_q);
  assign buf_empty = (wptr_q == rptr_q);
  assign buf_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head      = buf_q[rptr_q[AW-1:0]];

  assign mem_ready_o = run & ~dir_q & in_left & ~buf_full;
  assign fifo_push_o = run & ~dir_q & ~buf_empty & ~fifo_full_i;
  assign fifo_data_o = (run & ~dir_q & ~buf_empty) ? head : '0;

  assign fifo_pop_o  = run & dir_q & ~fifo_empty_i & ~buf_full & in_left;
  assign mem_valid_o = run & dir_q & ~buf_empty;
  assign mem_data_o  = mem_valid_o ? head : '0;

  assign wr_en   = dir_q ? fifo_pop_o : (mem_valid_i & mem_ready_o);
  assign wr_data = dir_q ? fifo_data_i : mem_data_i;
  assign rd_en   = dir_q ? (mem_valid_o & mem_ready_i) : fifo_push_o;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  // Next state: counters follow the buffer traffic; completion looks at the
  // post-increment output count so DONE lands the cycle after the last beat.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    len_d     = len_q;
    wptr_d    = wptr_q + PW'(wr_en);
    rptr_d    = rptr_q + PW'(rd_en);
    in_cnt_d  = in_cnt_q + CNT_W'(wr_en);
    out_cnt_d = out_cnt_q + CNT_W'(rd_en);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d     = dir_i;
          len_d     = len_i;
          wptr_d    = '0;
          rptr_d    = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN:     if (out_cnt_d == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start.
    if (clear_i) begin
      state_d   = IDLE;
      wptr_d    = '0;
      rptr_d    = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Buffer storage; cleared on reset so the head never shows X.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q <= '0;
    end else if (wr_en) begin
      buf_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mage_dma_ch_driver.sv
// Self-checking bench for mage_dma_ch_driver: table of directed transfers,
// hand sequences for clear/start corner cases, and random transfers checked
// against a word-count model of the channel.
module tb_mage_dma_ch_driver;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0, dir_i = 1'b0, clear_i = 1'b0;
  logic [CNT_W-1:0]  len_i = '0;
  logic              busy_o, done_o;
  logic              mem_valid_i = 1'b0, mem_ready_i = 1'b0;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              mem_ready_o, mem_valid_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              fifo_push_o, fifo_pop_o;
  logic [DATA_W-1:0] fifo_data_o;
  logic              fifo_full_i = 1'b0, fifo_empty_i = 1'b1;
  logic [DATA_W-1:0] fifo_data_i = '0;

  always #5 clk_i = ~clk_i;

  mage_dma_ch_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .dir_i(dir_i),
    .len_i(len_i), .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .mem_ready_o(mem_ready_o), .mem_valid_o(mem_valid_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
    .fifo_full_i(fifo_full_i), .fifo_pop_o(fifo_pop_o),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i)
  );

  int n_vec = 0;
  int n_err = 0;
  int cur_c = 0;

  typedef struct {
    bit          dir;
    int          len;
    logic [31:0] base;
    int          lo;        // stall window start (dir 0, mode 1)
    int          hi;        // stall window end
    int          mode;      // 0 none, 1 window/toggle, 2 random
    int          exp_done;  // cycle of done_o, -1 = don't care
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cur_c, act, exp);
    end
  endtask

  // One transfer, cycle 0 = the cycle in which start_i is sampled.
  // Model: acc = words taken in, dlv = words handed out, occ = acc - dlv.
  task automatic run_xfer(input bit dir, input int len, input logic [31:0] base,
                          input int lo, input int hi, input int mode,
                          input int clr_cyc, input int stray_cyc, input int exp_done);
    logic [31:0] words[$];
    logic [31:0] mage[$];
    logic [31:0] prev_data;
    int acc, dlv, occ, ms, c, done_cyc, done_cnt, bound, extra;
    bit prev_hold, cleared, stall, e_rdy, e_push, e_pop, e_mv;
    extra = 2;
    for (int i = 0; i < len; i++) words.push_back(mode == 2 ? $urandom : base + i);
    if (dir) begin
      foreach (words[i]) mage.push_back(words[i]);
      for (int i = 0; i < extra; i++) mage.push_back($urandom);
    end
    acc = 0; dlv = 0; ms = 0; c = 0; done_cyc = -1; done_cnt = 0;
    prev_hold = 0; prev_data = '0; cleared = 0;
    bound = 100 + 10 * len;
    forever begin
      cur_c   = c;
      start_i = (c == 0) || (c == stray_cyc);
      dir_i   = (c == 0) ? dir : ~dir;
      len_i   = (c == 0) ? CNT_W'(len) : CNT_W'(len + 5);
      clear_i = (c == clr_cyc);
      case (mode)
        1:       stall = dir ? (c % 2 == 1) : (c >= lo && c <= hi);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      fifo_full_i  = !dir && stall;
      mem_ready_i  = !(dir && stall);
      mem_valid_i  = !dir && acc < len && !(mode == 2 && $urandom_range(0, 3) == 0);
      mem_data_i   = (acc < len) ? words[acc] : $urandom;
      fifo_empty_i = (mage.size() == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
      fifo_data_i  = (mage.size() > 0) ? mage[0] : $urandom;
      #1;
      occ    = acc - dlv;
      e_rdy  = ms == 1 && !dir && acc < len && occ < DEPTH;
      e_push = ms == 1 && !dir && occ > 0 && !fifo_full_i;
      e_pop  = ms == 1 && dir && !fifo_empty_i && occ < DEPTH && acc < len;
      e_mv   = ms == 1 && dir && occ > 0;
      chk("ctl{busy,done,rdy,mvld,push,pop}",
          {busy_o, done_o, mem_ready_o, mem_valid_o, fifo_push_o, fifo_pop_o},
          {ms != 0, ms == 2, e_rdy, e_mv, e_push, e_pop});
      if (e_push && fifo_push_o && dlv < len) chk("push_data", fifo_data_o, words[dlv]);
      if (e_mv && mem_valid_o && dlv < len)   chk("mem_data", mem_data_o, words[dlv]);
      if (prev_hold) chk("hold{vld,data}", {mem_valid_o, mem_data_o}, {1'b1, prev_data});
      prev_hold = dir && mem_valid_o && !mem_ready_i;
      prev_data = mem_data_o;
      if (done_o) begin done_cnt++; done_cyc = c; end
      // environment follows what the DUT actually did at this edge
      if (mem_valid_i && mem_ready_o) acc++;
      if (fifo_pop_o) begin
        if (mage.size() > 0) void'(mage.pop_front());
        acc++;
      end
      if (fifo_push_o) dlv++;
      if (mem_valid_o && mem_ready_i) dlv++;
      if (clear_i) begin
        ms = 0; cleared = 1;
      end else begin
        case (ms)
          0:       if (start_i) ms = (len == 0) ? 2 : 1;
          1:       if (dlv >= len) ms = 2;
          default: ms = 0;
        endcase
      end
      @(posedge clk_i); #1;
      c++;
      if (ms == 0) begin
        cur_c = c;
        start_i = 0; clear_i = 0; mem_valid_i = 0; fifo_full_i = 0;
        fifo_empty_i = 1; mem_ready_i = 1;
        #1;
        chk("idle_after", {busy_o, done_o, mem_ready_o, mem_valid_o, fifo_push_o, fifo_pop_o}, 6'b0);
        @(posedge clk_i); #1;
        break;
      end
      if (c > bound) begin
        n_vec++; n_err++;
        $display("FAIL timeout: transfer dir %0d len %0d not done after %0d cycles", dir, len, c);
        clear_i = 1; @(posedge clk_i); #1; clear_i = 0;
        break;
      end
    end
    if (!cleared) begin
      chk("done_count", done_cnt, 1);
      chk("words_moved", dlv, len);
      if (dir) chk("mage_left", mage.size(), extra);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    end else begin
      chk("no_done_on_clear", done_cnt, 0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 8, 32'h100, 0, -1, 0, 10};
    tbl[1] = '{1'b0, 6, 32'h200, 3,  9, 1, 15};
    tbl[2] = '{1'b1, 5, 32'hA0,  0, -1, 1, 11};
    tbl[3] = '{1'b0, 0, 32'h0,   0, -1, 0,  1};
    tbl[4] = '{1'b1, 1, 32'h55,  0, -1, 0,  3};
    tbl[5] = '{1'b0, 3, 32'h30,  0, -1, 0,  5};

    // reset: every output low
    #12;
    chk("rst_ctl", {busy_o, done_o, mem_ready_o, mem_valid_o, fifo_push_o, fifo_pop_o}, 6'b0);
    chk("rst_data", {mem_data_o, fifo_data_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_busy", busy_o, 1'b0);

    for (int i = 0; i < 6; i++)
      run_xfer(tbl[i].dir, tbl[i].len, tbl[i].base, tbl[i].lo, tbl[i].hi,
               tbl[i].mode, -1, -1, tbl[i].exp_done);

    // start pulsed mid-transfer with other dir/len: no effect on schedule
    run_xfer(1'b0, 6, 32'h400, 0, -1, 0, -1, 3, 8);
    // clear at cycle 4 of a len-10 transfer, then a clean restart
    run_xfer(1'b0, 10, 32'h500, 0, -1, 0, 4, -1, -1);
    run_xfer(1'b0, 3, 32'h300, 0, -1, 0, -1, -1, 5);
    run_xfer(1'b1, 10, 32'h600, 0, -1, 0, 4, -1, -1);
    run_xfer(1'b1, 4, 32'h700, 0, -1, 0, -1, -1, 6);

    // clear and start in the same idle cycle: clear wins
    start_i = 1; clear_i = 1; dir_i = 0; len_i = 16'd4;
    @(posedge clk_i); #1;
    start_i = 0; clear_i = 0;
    #1;
    chk("clr_vs_start", {busy_o, done_o, mem_ready_o}, 3'b0);
    @(posedge clk_i); #1;
    chk("clr_vs_start2", {busy_o, done_o}, 2'b0);

    // random transfers under random backpressure on both sides
    for (int t = 0; t < 24; t++)
      run_xfer(1'($urandom_range(0, 1)), $urandom_range(1, 20), 32'h0, 0, -1, 2, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mage_dma_ch_driver.md
# mage_dma_ch_driver

Initiator end of one Mage HW-FIFO DMA channel: the memory-side counterpart that drives push/pop requests into the Mage streaming interface and consumes its full/empty/data responses. One instance serves one channel. Per transfer it moves `len_i` words in one direction:
- **to Mage:** a memory-side valid/ready stream is pushed into the Mage input FIFO.
- **from Mage:** words are popped from the Mage output FIFO and presented on a memory-side valid/ready stream.

A DEPTH-entry internal buffer decouples the two sides. It sits between the system DMA and `hw_fifo_req`/`hw_fifo_resp` of a Mage channel.

## Interface
- `DATA_W`, 32, word width; equals Mage N_BITS.
- `DEPTH`, 4, internal buffer entries; power of two, ≥2.
- `CNT_W`, 16, transfer-length counter width.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  launch transfer; sampled only in IDLE.
- `dir_i`  in  1  0 = memory→Mage (push), 1 = Mage→memory (pop); latched at start.
- `len_i`  in  CNT_W  word count; latched at start.
- `clear_i`  in  1  synchronous abort/flush.
- `busy_o`  out  1  high while not IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `mem_valid_i`  in  1  memory-side input stream valid (dir 0).
- `mem_data_i`  in  DATA_W  memory-side input stream data (dir 0).
- `mem_ready_o`  out  1  memory-side input stream ready (dir 0).
- `mem_valid_o`  out  1  memory-side output stream valid (dir 1).
- `mem_data_o`  out  DATA_W  memory-side output stream data (dir 1).
- `mem_ready_i`  in  1  memory-side output stream ready (dir 1).
- `fifo_push_o`  out  1  push request to Mage input FIFO.
- `fifo_data_o`  out  DATA_W  push data.
- `fifo_full_i`  in  1  Mage input FIFO full.
- `fifo_pop_o`  out  1  pop request to Mage output FIFO.
- `fifo_empty_i`  in  1  Mage output FIFO empty.
- `fifo_data_i`  in  DATA_W  Mage FIFO head data; first-word fall-through, valid in the same cycle as the pop.

## Operation
**FSM states:** IDLE, RUN, DONE.
- **IDLE → RUN:** on `start_i`. Latch `dir_i` and `len_i`; zero `in_cnt`, `out_cnt` and the buffer.
- **IDLE → DONE:** if `len_i` == 0 at start.
- **RUN → DONE:** when `out_cnt` == len.
- **DONE → IDLE:** unconditionally after one cycle; `done_o` = 1 in DONE only.
- **`start_i` outside IDLE:** ignored.

**clear_i:**
- In any state: next state IDLE, buffer emptied, counters zeroed, no `done_o`.
- Takes priority over every other event, including a `start_i` in the same cycle.

**Buffer:**
- Circular, DEPTH entries; read/write pointers of log2(DEPTH)+1 bits.
- Simultaneous write and read allowed, including when full (the read frees the slot only on the next cycle; see `mem_ready_o`) and when empty (write only).

**dir 0 (memory → Mage):**
- `mem_ready_o` = RUN & `in_cnt` < len & buffer not full. Registered-state terms only; no combinational path from `fifo_full_i`.
- A beat is accepted on `mem_valid_i` & `mem_ready_o`; `in_cnt`++.
- `fifo_push_o` = RUN & buffer non-empty & !`fifo_full_i`.
- `fifo_data_o` = buffer head. Each push pops the buffer; `out_cnt`++.
- `mem_valid_o` = 0 and `fifo_pop_o` = 0 throughout.

**dir 1 (Mage → memory):**
- `fifo_pop_o` = RUN & !`fifo_empty_i` & buffer not full & `in_cnt` < len.
- Each pop writes `fifo_data_i` into the buffer; `in_cnt`++.
- `mem_valid_o` = RUN & buffer non-empty; `mem_data_o` = buffer head.
- Handshake `mem_valid_o` & `mem_ready_i`: `out_cnt`++.
- `mem_ready_o` = 0 and `fifo_push_o` = 0 throughout.

**Invariants:**
- Never push while `fifo_full_i`; never pop while `fifo_empty_i`.
- Never more than len words in either direction.
- Counter arithmetic is CNT_W-bit unsigned; max len = 2^CNT_W−1 with no wrap.

## Timing
**Reset values:** all outputs 0; state IDLE; counters and pointers 0.

**Zero-backpressure schedule** (start sampled in cycle 0):
- Cycle 1: RUN; `mem_ready_o`/`fifo_pop_o` can assert.
- Cycle 2: first word available at the other side (`fifo_push_o`/`mem_valid_o`).
- Cycle len: last beat accepted.
- Cycle len+1: last beat delivered.
- Cycle len+2: DONE, `done_o` = 1.
- Cycle len+3: IDLE.

**Throughput:** one word per cycle sustained; buffer occupancy ≤1 with no stalls.

**Data path:** one register stage (the buffer) between the two sides in both directions; `busy_o` is decoded from state.

**Backpressure:**
- `fifo_full_i` (dir 0) or `mem_ready_i` low (dir 1) fills the buffer.
- Input side stalls exactly when the buffer holds DEPTH words.
- No word is lost or duplicated.

## Test plan
- **Reset then idle:** all outputs 0, `busy_o` 0.
- **dir 0, len 8, data 0x100..0x107, no stalls:** `fifo_push_o` high cycles 2–9 with data in order; `done_o` cycle 10 only.
- **dir 0, len 6, `fifo_full_i` high cycles 3–9:**
  - `mem_ready_o` drops after DEPTH=4 words are buffered.
  - Pushes resume cycle 10; 6 words arrive in order, no push while full; then `done_o`.
- **dir 1, len 5, Mage FIFO pre-loaded with 0xA0..0xA4, `mem_ready_i` toggling 1/0:**
  - Exactly 5 pops, none while empty.
  - `mem_data_o` sequence 0xA0..0xA4; `mem_valid_o` held stable while not ready; single `done_o`.
- **len 0 start:** `done_o` in cycle 1, no push/pop.
- **`clear_i` mid-transfer and `start_i` during RUN:**
  - `clear_i` at cycle 4 of a len-10 transfer: IDLE next cycle, no `done_o`; a new start transfers len words from an empty buffer.
  - `start_i` pulsed during RUN: no effect.
